// File: rtl/systolic_matmul_engine.sv
// Output-stationary DIM x DIM systolic matrix multiplier (C = A*B or C += A*B)
// with operand load FSM, on-the-fly diagonal skew and a row-serial result drain.
module systolic_matmul_engine #(
    parameter int  WIDTH = 8,
    parameter int  DIM   = 3,
    localparam int ACC_W = 2 * WIDTH + $clog2(DIM),
    localparam int IDX_W = ($clog2(DIM) > 1) ? $clog2(DIM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 acc_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] a_col,
    input  logic [DIM*WIDTH-1:0] b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*ACC_W-1:0] out_data,
    output logic [IDX_W-1:0]     out_row,
    output logic                 busy,
    output logic                 done
);
    localparam int STEPS  = 3 * DIM - 2;
    localparam int STEP_W = $clog2(STEPS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     k_reg, k_next;
    logic [STEP_W-1:0]    step_reg, step_next;
    logic [IDX_W-1:0]     r_reg, r_next;
    logic                 signed_reg, signed_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 done_reg, done_next;
    logic [DIM*ACC_W-1:0] out_data_reg;
    logic                 out_load;
    logic                 clear_acc;
    logic                 compute_en;
    logic [IDX_W-1:0]     drain_sel;
    logic [DIM*ACC_W-1:0] row_data;

    logic [DIM*WIDTH-1:0] a_mem [DIM];
    logic [DIM*WIDTH-1:0] b_mem [DIM];
    logic [WIDTH-1:0]     left_in [DIM];
    logic [WIDTH-1:0]     top_in [DIM];
    logic [WIDTH-1:0]     a_fwd [DIM][DIM-1];
    logic [WIDTH-1:0]     b_fwd [DIM-1][DIM];
    logic [ACC_W-1:0]     acc_all [DIM][DIM];

    assign compute_en = (state_reg == COMPUTE);
    assign in_ready   = (state_reg == LOAD);
    assign busy       = (state_reg != IDLE);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_row    = r_reg;
    assign done       = done_reg;

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        step_next      = step_reg;
        r_next         = r_reg;
        signed_next    = signed_reg;
        out_valid_next = out_valid_reg;
        done_next      = 1'b0;
        out_load       = 1'b0;
        clear_acc      = 1'b0;
        drain_sel      = r_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    signed_next = signed_mode;
                    clear_acc   = !acc_mode;
                    k_next      = '0;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (k_reg == LAST_IDX) begin
                        k_next     = '0;
                        step_next  = '0;
                        state_next = COMPUTE;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (step_reg == LAST_STEP) begin
                    step_next  = '0;
                    r_next     = '0;
                    state_next = DRAIN;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end
            DRAIN: begin
                // First DRAIN cycle primes the output register; afterwards each
                // accepted row immediately loads the next one.
                if (!out_valid_reg) begin
                    out_load       = 1'b1;
                    out_valid_next = 1'b1;
                end else if (out_ready) begin
                    if (r_reg == LAST_IDX) begin
                        out_valid_next = 1'b0;
                        r_next         = '0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        r_next    = r_reg + 1'b1;
                        drain_sel = r_reg + 1'b1;
                        out_load  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            step_reg      <= '0;
            r_reg         <= '0;
            signed_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            out_data_reg  <= '0;
            for (int k = 0; k < DIM; k++) begin
                a_mem[k] <= '0;
                b_mem[k] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            step_reg      <= step_next;
            r_reg         <= r_next;
            signed_reg    <= signed_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
            if (out_load) begin
                out_data_reg <= row_data;
            end
            if (state_reg == LOAD && in_valid) begin
                a_mem[k_reg] <= a_col;
                b_mem[k_reg] <= b_row;
            end
        end
    end

    // Diagonal skew: row i sees A[i][t-i], column j sees B[t-j][j], zero outside.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            left_in[i] = '0;
            top_in[i]  = '0;
            for (int k = 0; k < DIM; k++) begin
                if (int'(step_reg) == i + k) begin
                    left_in[i] = a_mem[k][i*WIDTH +: WIDTH];
                    top_in[i]  = b_mem[k][i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        row_data = '0;
        for (int j = 0; j < DIM; j++) begin
            row_data[j*ACC_W +: ACC_W] = acc_all[drain_sel][j];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_row
            for (gj = 0; gj < DIM; gj++) begin : g_col
                logic [WIDTH-1:0] a_in, b_in;
                logic [ACC_W-1:0] a_ext, b_ext, prod, acc_reg;

                if (gj == 0) begin : g_a_edge
                    assign a_in = left_in[gi];
                end else begin : g_a_hop
                    assign a_in = a_fwd[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign b_in = top_in[gj];
                end else begin : g_b_hop
                    assign b_in = b_fwd[gi-1][gj];
                end

                assign a_ext = {{(ACC_W-WIDTH){signed_reg & a_in[WIDTH-1]}}, a_in};
                assign b_ext = {{(ACC_W-WIDTH){signed_reg & b_in[WIDTH-1]}}, b_in};
                assign prod  = a_ext * b_ext;

                // Forwarding registers flush to zero outside COMPUTE so stale
                // operands never reach a neighbour on the next tile.
                if (gj < DIM - 1) begin : g_a_reg
                    logic [WIDTH-1:0] a_reg;
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) a_reg <= '0;
                        else        a_reg <= compute_en ? a_in : '0;
                    end
                    assign a_fwd[gi][gj] = a_reg;
                end
                if (gi < DIM - 1) begin : g_b_reg
                    logic [WIDTH-1:0] b_reg;
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) b_reg <= '0;
                        else        b_reg <= compute_en ? b_in : '0;
                    end
                    assign b_fwd[gi][gj] = b_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        acc_reg <= '0;
                    end else if (clear_acc) begin
                        acc_reg <= '0;
                    end else if (compute_en) begin
                        acc_reg <= acc_reg + prod;
                    end
                end
                assign acc_all[gi][gj] = acc_reg;
            end
        end
    endgenerate
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed + randomized bench for systolic_matmul_engine against a plain
// matrix-product reference model.
module tb_systolic_matmul_engine;
    localparam int WIDTH = 8;
    localparam int DIM   = 3;
    localparam int ACC_W = 2 * WIDTH + $clog2(DIM);
    localparam int IDX_W = ($clog2(DIM) > 1) ? $clog2(DIM) : 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 signed_mode = 1'b0;
    logic                 acc_mode = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DIM*WIDTH-1:0] a_col = '0;
    logic [DIM*WIDTH-1:0] b_row = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DIM*ACC_W-1:0] out_data;
    logic [IDX_W-1:0]     out_row;
    logic                 busy;
    logic                 done;

    systolic_matmul_engine #(.WIDTH(WIDTH), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .acc_mode(acc_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] mat_a [DIM][DIM];
    logic [WIDTH-1:0] mat_b [DIM][DIM];
    logic [ACC_W-1:0] model_c [DIM][DIM];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                model_c[i][j] = '0;
    endtask

    // C[i][j] (+)= sum_k A[i][k]*B[k][j], elements read as signed or unsigned.
    task automatic model_tile(input bit sgn, input bit accm);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                longint sum = 0;
                logic [63:0] sum_bits;
                logic [ACC_W-1:0] s;
                for (int k = 0; k < DIM; k++) begin
                    longint ea, eb;
                    ea = sgn ? longint'($signed(mat_a[i][k])) : longint'(mat_a[i][k]);
                    eb = sgn ? longint'($signed(mat_b[k][j])) : longint'(mat_b[k][j]);
                    sum += ea * eb;
                end
                sum_bits = sum;
                s = sum_bits[ACC_W-1:0];
                model_c[i][j] = accm ? model_c[i][j] + s : s;
            end
        end
    endtask

    function automatic logic [DIM*ACC_W-1:0] exp_row(input int r);
        logic [DIM*ACC_W-1:0] v;
        v = '0;
        for (int j = 0; j < DIM; j++) v[j*ACC_W +: ACC_W] = model_c[r][j];
        return v;
    endfunction

    task automatic pack_beat(input int k);
        for (int i = 0; i < DIM; i++) begin
            a_col[i*WIDTH +: WIDTH] = mat_a[i][k];
            b_row[i*WIDTH +: WIDTH] = mat_b[k][i];
        end
    endtask

    task automatic set_s1();
        mat_a = '{'{8'd9, 8'd3, 8'd2}, '{8'd5, 8'd1, 8'd1}, '{8'd0, 8'd1, 8'd5}};
        mat_b = '{'{8'd9, 8'd1, 8'd8}, '{8'd0, 8'd2, 8'd2}, '{8'd2, 8'd6, 8'd1}};
    endtask

    // Starts at the current negedge (so back-to-back start on the done cycle is
    // exercised) and returns at the negedge where done is observed.
    task automatic run_tile(input bit sgn, input bit accm, input bit gaps,
                            input bit stall, input bit lat);
        int t0;
        int n;
        logic [DIM*ACC_W-1:0] er;
        model_tile(sgn, accm);
        start = 1'b1; signed_mode = sgn; acc_mode = accm;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0; signed_mode = !sgn; acc_mode = !accm;
        chk("busy_after_start", busy, 1);
        chk("in_ready_load", in_ready, 1);
        chk("done_low", done, 0);
        for (int k = 0; k < DIM; k++) begin
            if (gaps && k == 1) begin
                in_valid = 1'b0; start = 1'b1; a_col = '1; b_row = '1;
                @(negedge clk);
                chk("in_ready_gap", in_ready, 1);
                start = 1'b0;
            end
            in_valid = 1'b1;
            pack_beat(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            start = (gaps && n == 2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("out_valid_rise", out_valid, 1);
        if (lat) chk("first_valid_latency", cyc - t0, 4 * DIM - 1);
        for (int r = 0; r < DIM; r++) begin
            er = exp_row(r);
            chk("out_valid", out_valid, 1);
            chk("out_row", out_row, r);
            chk("out_data", out_data, er);
            if (stall && r == 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_row", out_row, 1);
                    chk("stall_data", out_data, er);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        if (lat) chk("done_latency", cyc - t0, 5 * DIM - 1);
        $display("[TB] tile sgn=%0d acc=%0d gaps=%0d stall=%0d row0=%0h", sgn, accm, gaps, stall, exp_row(0));
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_s1();
        run_tile(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_tile(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_tile(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = (i == j) ? 8'hFF : 8'h00;
                mat_b[i][j] = 8'h7F;
            end
        run_tile(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_tile(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = 8'hFF;
                mat_b[i][j] = 8'hFF;
            end
        run_tile(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        set_s1();
        run_tile(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Abort a tile at COMPUTE step 3 with reset, then accumulate onto zero.
        @(negedge clk);
        start = 1'b1; acc_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < DIM; k++) begin
            in_valid = 1'b1;
            pack_beat(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_row", out_row, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        run_tile(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    mat_a[i][j] = WIDTH'($urandom_range(0, 255));
                    mat_b[i][j] = WIDTH'($urandom_range(0, 255));
                end
            run_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
